// File: rtl/maze_world_model.sv
// Grid-maze environment model: tracks robot cell/heading, answers wall sensors.
// Latency: one edge from command to new state; sensors follow the state combinationally.
// Backpressure: none; commands are sampled only on edges with en=1, goal latch blocks further steps.
module maze_world_model #(
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0,
    parameter int unsigned START_H = 1,
    parameter int unsigned GOAL_X  = 3,
    parameter int unsigned GOAL_Y  = 3,
    parameter logic [15:0] N_WALL  = 16'h0000,
    parameter logic [15:0] W_WALL  = 16'h0000,
    parameter int unsigned TURN_CW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       front,
    input  logic       turn,
    output logic       front_sensor,
    output logic       left_sensor,
    output logic [1:0] pos_x,
    output logic [1:0] pos_y,
    output logic [1:0] heading,
    output logic       bump,
    output logic       cmd_error,
    output logic       goal_reached,
    output logic [7:0] step_count
);

    localparam logic [1:0] SX = 2'(START_X);
    localparam logic [1:0] SY = 2'(START_Y);
    localparam logic [1:0] SH = 2'(START_H);
    localparam logic [1:0] GX = 2'(GOAL_X);
    localparam logic [1:0] GY = 2'(GOAL_Y);
    localparam logic       START_AT_GOAL = (SX == GX) && (SY == GY);

    // Outer boundary is always walled, so the indexed bit is a don't-care on edge cells.
    function automatic logic wall(input logic [1:0] cx, input logic [1:0] cy, input logic [1:0] d);
        logic [3:0] idx;
        logic [3:0] idx_east;
        logic [3:0] idx_south;
        idx       = {cy, cx};
        idx_east  = idx + 4'd1;
        idx_south = idx + 4'd4;
        case (d)
            2'd0:    wall = (cy == 2'd0) | N_WALL[idx];
            2'd1:    wall = (cx == 2'd3) | W_WALL[idx_east];
            2'd2:    wall = (cy == 2'd3) | N_WALL[idx_south];
            default: wall = (cx == 2'd0) | W_WALL[idx];
        endcase
    endfunction

    logic [1:0] left_dir;
    logic [1:0] next_x;
    logic [1:0] next_y;
    logic [1:0] turned_h;
    logic       step_ok;

    assign left_dir     = heading + 2'd3;
    assign front_sensor = wall(pos_x, pos_y, heading);
    assign left_sensor  = wall(pos_x, pos_y, left_dir);
    assign turned_h     = (TURN_CW != 0) ? heading + 2'd1 : heading + 2'd3;
    assign step_ok      = en && !goal_reached;

    always_comb begin
        next_x = pos_x;
        next_y = pos_y;
        case (heading)
            2'd0:    next_y = pos_y - 2'd1;
            2'd1:    next_x = pos_x + 2'd1;
            2'd2:    next_y = pos_y + 2'd1;
            default: next_x = pos_x - 2'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x        <= SX;
            pos_y        <= SY;
            heading      <= SH;
            bump         <= 1'b0;
            cmd_error    <= 1'b0;
            goal_reached <= START_AT_GOAL;
            step_count   <= 8'd0;
        end else begin
            bump      <= 1'b0;
            cmd_error <= 1'b0;
            if (step_ok) begin
                if (turn) begin
                    // Turn wins a front/turn conflict; the conflict itself is flagged.
                    heading   <= turned_h;
                    cmd_error <= front;
                    if (step_count != 8'hFF)
                        step_count <= step_count + 8'd1;
                end else if (front) begin
                    if (front_sensor) begin
                        bump <= 1'b1;
                    end else begin
                        pos_x <= next_x;
                        pos_y <= next_y;
                        if (step_count != 8'hFF)
                            step_count <= step_count + 8'd1;
                        if ((next_x == GX) && (next_y == GY))
                            goal_reached <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/maze_world_model.md
# maze_world_model

Behavioural-synthesizable environment model for the wall-following robot controller. It is the other end of the controller's sensor/command interface. Each clock it accepts the `front`/`turn` motor commands and updates the robot's position and heading in a parameterised 4x4 grid maze. It drives `front_sensor`/`left_sensor` back to the controller, which closes the loop for on-board and simulation runs of the robot FSMs.

## Interface
- `START_X`, default 0: reset column, 0..3.
- `START_Y`, default 0: reset row, 0..3; row 0 is the north edge.
- `START_H`, default 1: reset heading; N=0, E=1, S=2, W=3.
- `GOAL_X`, default 3: goal column.
- `GOAL_Y`, default 3: goal row.
- `N_WALL`, default 16'h0000: bit i=1 means a wall on the north side of cell i, where i = y*4+x.
- `W_WALL`, default 16'h0000: bit i=1 means a wall on the west side of cell i.
- `TURN_CW`, default 1: 1 means `turn` rotates clockwise (h+1); 0 means counter-clockwise (h+3).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: step enable; state updates only on edges where `en`=1.
- `front` in 1: move one cell forward.
- `turn` in 1: rotate 90 degrees.
- `front_sensor` out 1: 1 means a wall directly ahead of the current cell/heading.
- `left_sensor` out 1: 1 means a wall on the left of the current cell/heading.
- `pos_x`, `pos_y` out 2 each: current cell.
- `heading` out 2: current heading.
- `bump` out 1: one-cycle pulse; the last accepted `front` hit a wall.
- `cmd_error` out 1: one-cycle pulse; `front` and `turn` were both high on an accepted step.
- `goal_reached` out 1: sticky; the robot occupies the goal cell.
- `step_count` out 8: count of accepted moves plus rotations, saturating.

## Operation
- **Registered state:** x, y, h, bump, cmd_error, goal_reached, step_count. All outputs except the sensors come directly from these registers.
- **Sensors are Moore outputs.** They are combinational functions of x, y, h only. There is no combinational path from `front`/`turn`, so a Mealy controller can be connected without a loop.
- **Wall lookup.** wall(x,y,d) is:
  - N: `N_WALL[i]`, or 1 when y=0.
  - W: `W_WALL[i]`, or 1 when x=0.
  - S: 1 when y=3, else `N_WALL[i+4]`.
  - E: 1 when x=3, else `W_WALL[i+1]`.
- **Sensor equations:** `front_sensor` = wall(x,y,h); `left_sensor` = wall(x,y,(h+3) mod 4).
- **Accepted step:** an edge with `en`=1, `reset`=0 and `goal_reached`=0. On all other edges the state holds, except that the `bump`/`cmd_error` pulses clear to 0.
- **Step decode:**
  - `turn`=1, with `front` either value: h rotates per `TURN_CW` (mod 4) and step_count increments. If `front` was also 1, `cmd_error`=1 and no move occurs.
  - `front`=1, `turn`=0, wall ahead: position unchanged, `bump`=1, step_count unchanged.
  - `front`=1, `turn`=0, path open: move one cell. N: y-1; E: x+1; S: y+1; W: x-1. step_count increments.
  - Both commands 0: hold; pulses clear.
- **Goal flag.** `goal_reached` sets on the edge where the new position equals (`GOAL_X`,`GOAL_Y`). Once set, all further commands are ignored until `reset`.
- **step_count** saturates at 255 and does not wrap.
- **Position range.** The boundary walls guarantee that x and y never wrap.

## Timing
- **Reset values:**
  - x=`START_X`, y=`START_Y`, h=`START_H`.
  - `bump`=0, `cmd_error`=0, step_count=0.
  - `goal_reached`=1 if start equals goal, else 0.
  - Sensors reflect the start cell combinationally in the same cycle.
- **`reset` mid-operation:** overrides `en` and commands; start state is restored on that edge.
- **Latency:** one edge from command to updated position/heading. Sensors reflect the new state in the cycle after that edge, i.e. zero additional latency after the state update.
- **Pulse width:** `bump` and `cmd_error` are high for exactly one cycle after the offending step.

## Test plan
- **Open maze, forward and bump.** Defaults; after reset expect sensors front=0, left=1. Then 3 edges of `front`=1 -> x=3, y=0, `front_sensor`=1, step_count=3. A 4th `front` -> `bump`=1 for one cycle, x stays 3, count stays 3.
- **Turn and goal.** Continue from the previous case with `turn`=1 -> h=S, front=0, left=1, count=4. Then `front`x3 -> y=3, `goal_reached`=1, count=7. Further `turn`/`front` -> no change.
- **Internal wall.** `W_WALL`=16'h0002; reset -> `front_sensor`=1 at (0,0) facing E. `front`=1 -> bump=1, x=0.
- **Command conflict and enable.** Assert `front`=`turn`=1 -> h rotates, no move, `cmd_error` pulses, count+1. Repeat with `en`=0 -> no state change.
- **Reset mid-run.** After 5 moves, assert `reset` for one edge with `front`=1 -> x=0, y=0, h=E, count=0, pulses 0.
- **Saturation.** `TURN_CW`=1 with continuous `turn`=1 for 300 enabled edges -> step_count=255, h=(1+300) mod 4=1.
